conv2d_stream: RTL and testbench

Parametrised streaming 2-D convolution engine: KERNEL_SIZE×KERNEL_SIZE signed fixed-point kernel applied to a sliding window fed one image column per cycle from the line-buffer BRAMs. Successor of the fixed 3×3 Q1.7 convolver: configurable widths, formats and kernel size, valid-qualified pipeline, window-fill tracking, double-buffered kernel load, selectable rounding and a saturation flag. Sits between line-buffer read logic and the output pixel FIFO.

---
 rtl/conv2d_stream_if.sv | 40 ++++
 rtl/conv2d_stream.sv | 188 ++++++++++++++++++
 tb/tb_conv2d_stream.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv2d_stream_if.sv
// conv2d_stream_if: bundles the kernel-load and pixel-stream signals of
// conv2d_stream.
//   master : upstream side (line-buffer read logic / kernel loader)
//   slave  : the convolution engine
// Signals:
//   i_load_knl, i_knl_col  kernel column load strobe and data (row 0 in LSBs)
//   o_knl_done             one-cycle pulse after a full kernel is committed
//   i_valid, i_sol, i_col  image column stream (row 0 in LSBs)
//   o_valid, o_pixel,      result stream
//   o_sat
// Stream semantics: valid-only, no backpressure. A column is transferred on
// every rising clock edge where i_valid=1 and i_load_knl=0; i_sol and i_col
// are meaningful only then. o_pixel/o_sat are meaningful only while
// o_valid=1, and each cycle with o_valid=1 is exactly one result.
interface conv2d_stream_if #(
    parameter int KERNEL_SIZE = 3,
    parameter int NB_DATA     = 8,
    parameter int NB_COEFF    = 8,
    parameter int NB_OUTPUT   = 8
);
    logic                            i_load_knl;
    logic [KERNEL_SIZE*NB_COEFF-1:0] i_knl_col;
    logic                            o_knl_done;
    logic                            i_valid;
    logic                            i_sol;
    logic [KERNEL_SIZE*NB_DATA-1:0]  i_col;
    logic                            o_valid;
    logic [NB_OUTPUT-1:0]            o_pixel;
    logic                            o_sat;

    modport master (
        output i_load_knl, i_knl_col, i_valid, i_sol, i_col,
        input  o_knl_done, o_valid, o_pixel, o_sat
    );

    modport slave (
        input  i_load_knl, i_knl_col, i_valid, i_sol, i_col,
        output o_knl_done, o_valid, o_pixel, o_sat
    );
endinterface

// File: rtl/conv2d_stream.sv
// conv2d_stream: streaming KxK signed fixed-point 2-D convolution.
// One image column enters per accepted cycle; the window slides left and the
// result of the full window leaves 3 cycles after the accepting edge.
// Ports:
//   clk     system clock
//   i_nrst  asynchronous active-low reset
//   bus     conv2d_stream_if.slave (kernel load + column stream + results)
// Pipeline: window reg -> product regs -> sum reg -> rounded/saturated output.
module conv2d_stream #(
    parameter int NB_DATA     = 8,
    parameter int NBF_DATA    = 7,
    parameter int NB_COEFF    = 8,
    parameter int NBF_COEFF   = 7,
    parameter int NB_OUTPUT   = 8,
    parameter int NBF_OUTPUT  = 7,
    parameter int KERNEL_SIZE = 3,
    parameter int ROUND       = 1
) (
    input  logic           clk,
    input  logic           i_nrst,
    conv2d_stream_if.slave bus
);
    localparam int K       = KERNEL_SIZE;
    localparam int NB_P    = NB_DATA + NB_COEFF;
    localparam int NB_SUM  = NB_P + $clog2(K * K);
    localparam int S       = NBF_DATA + NBF_COEFF - NBF_OUTPUT;
    localparam int NB_FILL = $clog2(K + 1);
    localparam int NB_KCNT = $clog2(K);

    // Rounding offset and output limits, held one bit wider than the sum so
    // the rounding add can never wrap.
    localparam logic signed [NB_SUM:0] RND_K = (ROUND != 0 && S > 0)
        ? (NB_SUM+1)'(longint'(1) <<< (S > 0 ? S - 1 : 0)) : (NB_SUM+1)'(0);
    localparam logic signed [NB_SUM:0] OMAX =
        (NB_SUM+1)'((longint'(1) <<< (NB_OUTPUT - 1)) - 1);
    localparam logic signed [NB_SUM:0] OMIN = ~OMAX;

    typedef logic [K*NB_COEFF-1:0] kcol_t;
    typedef logic [K*NB_DATA-1:0]  dcol_t;

    kcol_t                    shadow_q [K];
    kcol_t                    active_q [K];
    logic [NB_KCNT-1:0]       knl_cnt_q;
    logic                     knl_done_q;
    dcol_t                    win_q [K];
    logic [NB_FILL-1:0]       fill_q, fill_d;
    logic                     v1_q, v2_q, v3_q, v4_q;
    logic signed [NB_P-1:0]   prod_q [K*K];
    logic signed [NB_P-1:0]   prod_d [K*K];
    logic signed [NB_SUM-1:0] sum_q, sum_d;
    logic signed [NB_SUM:0]   ext_s, rnd_s;
    logic [NB_OUTPUT-1:0]     pix_q, pix_d;
    logic                     sat_q, sat_d;
    logic                     load, accept, commit;

    // A kernel load always wins over an image column in the same cycle.
    assign load   = bus.i_load_knl;
    assign accept = bus.i_valid && !bus.i_load_knl;
    assign commit = load && (knl_cnt_q == NB_KCNT'(K - 1));

    // Fill count: number of columns of the current line in the window, capped at K.
    always_comb begin
        fill_d = fill_q;
        if (accept) begin
            if (bus.i_sol) begin
                fill_d = NB_FILL'(1);
            end else if (fill_q != NB_FILL'(K)) begin
                fill_d = fill_q + 1'b1;
            end
        end
    end

    // Kernel: columns collect in the shadow; the last column commits the whole
    // kernel (including the column arriving now) to the active copy.
    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) begin
            for (int c = 0; c < K; c++) begin
                shadow_q[c] <= '0;
                active_q[c] <= '0;
            end
            knl_cnt_q  <= '0;
            knl_done_q <= 1'b0;
        end else begin
            knl_done_q <= commit;
            if (load) begin
                shadow_q[knl_cnt_q] <= bus.i_knl_col;
                if (commit) begin
                    for (int c = 0; c < K - 1; c++) begin
                        active_q[c] <= shadow_q[c];
                    end
                    active_q[K-1] <= bus.i_knl_col;
                    knl_cnt_q     <= '0;
                end else begin
                    knl_cnt_q <= knl_cnt_q + 1'b1;
                end
            end
        end
    end

    // Stage 1: sliding window, newest column on the right (index K-1).
    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) begin
            for (int c = 0; c < K; c++) begin
                win_q[c] <= '0;
            end
            fill_q <= '0;
            v1_q   <= 1'b0;
        end else begin
            fill_q <= fill_d;
            v1_q   <= accept && (fill_d == NB_FILL'(K));
            if (accept) begin
                for (int c = 0; c < K - 1; c++) begin
                    win_q[c] <= win_q[c+1];
                end
                win_q[K-1] <= bus.i_col;
            end
        end
    end

    // Operands are sign-extended to the product width first so the multiply
    // is done at full precision regardless of context-width rules.
    always_comb begin
        for (int c = 0; c < K; c++) begin
            for (int r = 0; r < K; r++) begin
                prod_d[c*K+r] = NB_P'($signed(win_q[c][r*NB_DATA +: NB_DATA]))
                              * NB_P'($signed(active_q[c][r*NB_COEFF +: NB_COEFF]));
            end
        end
    end

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < K * K; i++) begin
            sum_d = sum_d + NB_SUM'(prod_q[i]);
        end
    end

    // Output scaling: optional half-up rounding, arithmetic shift, saturation.
    always_comb begin
        ext_s = (NB_SUM+1)'(sum_q);
        rnd_s = (ext_s + RND_K) >>> S;
        pix_d = rnd_s[NB_OUTPUT-1:0];
        sat_d = 1'b0;
        if (rnd_s > OMAX) begin
            pix_d = {1'b0, {(NB_OUTPUT-1){1'b1}}};
            sat_d = 1'b1;
        end else if (rnd_s < OMIN) begin
            pix_d = {1'b1, {(NB_OUTPUT-1){1'b0}}};
            sat_d = 1'b1;
        end
    end

    // Stages 2..4: products, sum, output. Data registers load only with valid.
    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) begin
            for (int i = 0; i < K * K; i++) begin
                prod_q[i] <= '0;
            end
            sum_q <= '0;
            pix_q <= '0;
            sat_q <= 1'b0;
            v2_q  <= 1'b0;
            v3_q  <= 1'b0;
            v4_q  <= 1'b0;
        end else begin
            v2_q <= v1_q;
            v3_q <= v2_q;
            v4_q <= v3_q;
            if (v1_q) begin
                for (int i = 0; i < K * K; i++) begin
                    prod_q[i] <= prod_d[i];
                end
            end
            if (v2_q) begin
                sum_q <= sum_d;
            end
            if (v3_q) begin
                pix_q <= pix_d;
                sat_q <= sat_d;
            end
        end
    end

    assign bus.o_knl_done = knl_done_q;
    assign bus.o_valid    = v4_q;
    assign bus.o_pixel    = pix_q;
    assign bus.o_sat      = sat_q;
endmodule

// File: tb/tb_conv2d_stream.sv
// Bench for conv2d_stream: three instances (K=3 round, K=3 truncate,
// K=5 wide output) checked by a table of constant vectors, hand sequences,
// and a window-sum reference model feeding per-instance expected queues.
module tb_conv2d_stream;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        load3, valid3, sol3;
    logic [23:0] knl3, col3;
    logic        load5, valid5, sol5;
    logic [39:0] knl5, col5;

    conv2d_stream_if #(.KERNEL_SIZE(3), .NB_DATA(8), .NB_COEFF(8), .NB_OUTPUT(8))  bus_a ();
    conv2d_stream_if #(.KERNEL_SIZE(3), .NB_DATA(8), .NB_COEFF(8), .NB_OUTPUT(8))  bus_b ();
    conv2d_stream_if #(.KERNEL_SIZE(5), .NB_DATA(8), .NB_COEFF(8), .NB_OUTPUT(10)) bus_c ();

    assign bus_a.i_load_knl = load3;  assign bus_b.i_load_knl = load3;
    assign bus_a.i_knl_col  = knl3;   assign bus_b.i_knl_col  = knl3;
    assign bus_a.i_valid    = valid3; assign bus_b.i_valid    = valid3;
    assign bus_a.i_sol      = sol3;   assign bus_b.i_sol      = sol3;
    assign bus_a.i_col      = col3;   assign bus_b.i_col      = col3;
    assign bus_c.i_load_knl = load5;
    assign bus_c.i_knl_col  = knl5;
    assign bus_c.i_valid    = valid5;
    assign bus_c.i_sol      = sol5;
    assign bus_c.i_col      = col5;

    conv2d_stream #(.ROUND(1)) dut_a (.clk(clk), .i_nrst(rst_n), .bus(bus_a));
    conv2d_stream #(.ROUND(0)) dut_b (.clk(clk), .i_nrst(rst_n), .bus(bus_b));
    conv2d_stream #(.KERNEL_SIZE(5), .NB_OUTPUT(10), .NBF_OUTPUT(8), .ROUND(1))
        dut_c (.clk(clk), .i_nrst(rst_n), .bus(bus_c));

    logic obs_v [3];
    logic obs_s [3];
    int   obs_p [3];
    assign obs_v[0] = bus_a.o_valid; assign obs_s[0] = bus_a.o_sat; assign obs_p[0] = int'($signed(bus_a.o_pixel));
    assign obs_v[1] = bus_b.o_valid; assign obs_s[1] = bus_b.o_sat; assign obs_p[1] = int'($signed(bus_b.o_pixel));
    assign obs_v[2] = bus_c.o_valid; assign obs_s[2] = bus_c.o_sat; assign obs_p[2] = int'($signed(bus_c.o_pixel));

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Expected entry: {due cycle[31:0], sat, pixel[9:0]}
    logic [42:0] exp_q [3][$];
    int kern [2][7][7];
    int shad [2][7][7];
    int win  [2][7][7];
    int fill [2];
    int kcnt [2];

    task automatic model_reset(input int m);
        for (int c = 0; c < 7; c++)
            for (int r = 0; r < 7; r++) begin
                kern[m][c][r] = 0; shad[m][c][r] = 0; win[m][c][r] = 0;
            end
        fill[m] = 0;
        kcnt[m] = 0;
    endtask

    task automatic model_step(input int m, input int k, input logic ld, input logic v, input logic s,
                              input logic [55:0] kc, input logic [55:0] dc,
                              output bit emit, output longint sum);
        emit = 0;
        sum  = 0;
        if (ld) begin
            for (int r = 0; r < k; r++) shad[m][kcnt[m]][r] = int'($signed(kc[r*8 +: 8]));
            if (kcnt[m] == k - 1) begin
                for (int c = 0; c < k; c++)
                    for (int r = 0; r < k; r++) kern[m][c][r] = shad[m][c][r];
                kcnt[m] = 0;
            end else begin
                kcnt[m]++;
            end
        end else if (v) begin
            for (int c = 0; c < k - 1; c++)
                for (int r = 0; r < k; r++) win[m][c][r] = win[m][c+1][r];
            for (int r = 0; r < k; r++) win[m][k-1][r] = int'($signed(dc[r*8 +: 8]));
            fill[m] = s ? 1 : ((fill[m] < k) ? fill[m] + 1 : k);
            if (fill[m] == k) begin
                emit = 1;
                for (int c = 0; c < k; c++)
                    for (int r = 0; r < k; r++) sum += longint'(win[m][c][r]) * kern[m][c][r];
            end
        end
    endtask

    function automatic logic [42:0] pack_exp(input longint sum, input int s, input bit rnd,
                                             input int nbo, input int due);
        longint v, mx, mn;
        bit sat;
        logic [9:0] p;
        v   = (rnd && s > 0) ? ((sum + (longint'(1) <<< (s - 1))) >>> s) : (sum >>> s);
        mx  = (longint'(1) <<< (nbo - 1)) - 1;
        mn  = -mx - 1;
        sat = 0;
        if (v > mx) begin v = mx; sat = 1; end
        else if (v < mn) begin v = mn; sat = 1; end
        p = 10'(v);
        return {due[31:0], sat, p};
    endfunction

    // Acceptance at the posedge read as cyc=n shows up at the negedge where cyc=n+4.
    always @(posedge clk or negedge rst_n) begin : model3
        bit     em;
        longint sm;
        if (!rst_n) begin
            model_reset(0);
            exp_q[0].delete();
            exp_q[1].delete();
        end else begin
            model_step(0, 3, load3, valid3, sol3, 56'(knl3), 56'(col3), em, sm);
            if (em) begin
                exp_q[0].push_back(pack_exp(sm, 7, 1'b1, 8, cyc + 4));
                exp_q[1].push_back(pack_exp(sm, 7, 1'b0, 8, cyc + 4));
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin : model5
        bit     em;
        longint sm;
        if (!rst_n) begin
            model_reset(1);
            exp_q[2].delete();
        end else begin
            model_step(1, 5, load5, valid5, sol5, 56'(knl5), 56'(col5), em, sm);
            if (em) exp_q[2].push_back(pack_exp(sm, 6, 1'b1, 10, cyc + 4));
        end
    end

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin : monitor
        logic [42:0] e;
        if (rst_n) begin
            for (int d = 0; d < 3; d++) begin
                if (obs_v[d]) begin
                    if (exp_q[d].size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_valid_%0d actual=1 required=0 cycle=%0d", d, cyc);
                    end else begin
                        e = exp_q[d].pop_front();
                        chk($sformatf("pixel_%0d", d), obs_p[d], int'($signed(e[9:0])));
                        chk($sformatf("sat_%0d", d), obs_s[d], e[10]);
                        chk($sformatf("out_cycle_%0d", d), cyc, int'(e[42:11]));
                    end
                end else if (exp_q[d].size() != 0) begin
                    e = exp_q[d][0];
                    if (int'(e[42:11]) <= cyc) begin
                        checks++;
                        failures++;
                        $display("FAIL missing_valid_%0d actual=0 required=1 cycle=%0d", d, cyc);
                        void'(exp_q[d].pop_front());
                    end
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic step3(input logic ld, input logic [23:0] kc, input logic v, input logic s,
                         input logic [23:0] c);
        load3 = ld; knl3 = kc; valid3 = v; sol3 = s; col3 = c;
        @(negedge clk);
    endtask

    task automatic idle3();
        step3(1'b0, 24'h0, 1'b0, 1'b0, 24'h0);
    endtask

    task automatic step5(input logic ld, input logic [39:0] kc, input logic v, input logic s,
                         input logic [39:0] c);
        load5 = ld; knl5 = kc; valid5 = v; sol5 = s; col5 = c;
        @(negedge clk);
    endtask

    task automatic load_knl3(input logic [7:0] k_all, input logic [7:0] k_ctr);
        logic [23:0] kc;
        for (int c = 0; c < 3; c++) begin
            kc = {3{k_all}};
            if (c == 1) kc[15:8] = k_ctr;
            step3(1'b1, kc, 1'b0, 1'b0, 24'h0);
            chk($sformatf("knl_done_a_col%0d", c), bus_a.o_knl_done, (c == 2));
        end
    endtask

    task automatic stream3(input int n, input logic [7:0] pix);
        for (int i = 0; i < n; i++) step3(1'b0, 24'h0, 1'b1, (i == 0), {3{pix}});
    endtask

    function automatic logic [7:0] rand_coeff();
        if ($urandom_range(0, 1) == 1) return 8'($urandom());
        return 8'($urandom_range(0, 31) - 16);
    endfunction

    typedef struct {
        logic [7:0] k_all;
        logic [7:0] k_ctr;
        logic [7:0] pix;
        logic [7:0] exp_a;
        logic       sat_a;
        logic [7:0] exp_b;
        logic       sat_b;
    } vec_t;
    vec_t vecs [6];

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] kc;
        logic [39:0] kc5;
        rst_n = 1'b0;
        load3 = 0; knl3 = 0; valid3 = 0; sol3 = 0; col3 = 0;
        load5 = 0; knl5 = 0; valid5 = 0; sol5 = 0; col5 = 0;
        repeat (3) @(negedge clk);
        chk("rst_valid_a", bus_a.o_valid, 0);
        chk("rst_pixel_a", bus_a.o_pixel, 0);
        chk("rst_sat_a", bus_a.o_sat, 0);
        chk("rst_knl_done_a", bus_a.o_knl_done, 0);
        chk("rst_valid_c", bus_c.o_valid, 0);
        chk("rst_pixel_c", bus_c.o_pixel, 0);
        chk("rst_sat_c", bus_c.o_sat, 0);
        chk("rst_knl_done_c", bus_c.o_knl_done, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // k_all, k_ctr, pixel -> ROUND=1 result, sat ; ROUND=0 result, sat
        vecs[0] = '{8'h00, 8'h40, 8'h40, 8'h20, 1'b0, 8'h20, 1'b0};
        vecs[1] = '{8'h7F, 8'h7F, 8'h7F, 8'h7F, 1'b1, 8'h7F, 1'b1};
        vecs[2] = '{8'h7F, 8'h7F, 8'h80, 8'h80, 1'b1, 8'h80, 1'b1};
        vecs[3] = '{8'h00, 8'h01, 8'h40, 8'h01, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{8'h00, 8'hC0, 8'h40, 8'hE0, 1'b0, 8'hE0, 1'b0};
        vecs[5] = '{8'h00, 8'h01, 8'hC0, 8'h00, 1'b0, 8'hFF, 1'b0};
        for (int i = 0; i < 6; i++) begin
            load_knl3(vecs[i].k_all, vecs[i].k_ctr);
            stream3(4, vecs[i].pix);
            repeat (3) idle3();
            chk($sformatf("vec%0d_valid_a", i), bus_a.o_valid, 1);
            chk($sformatf("vec%0d_pixel_a", i), bus_a.o_pixel, vecs[i].exp_a);
            chk($sformatf("vec%0d_sat_a", i), bus_a.o_sat, vecs[i].sat_a);
            chk($sformatf("vec%0d_pixel_b", i), bus_b.o_pixel, vecs[i].exp_b);
            chk($sformatf("vec%0d_sat_b", i), bus_b.o_sat, vecs[i].sat_b);
        end

        // First output of a line: 3 cycles after the third column's acceptance.
        load_knl3(8'h00, 8'h40);
        stream3(3, 8'h40);
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("first_out_valid_t%0d", j), bus_a.o_valid, (j == 3));
            if (j < 3) idle3();
        end
        chk("first_out_pixel", bus_a.o_pixel, 8'h20);

        // Partial kernel load mid-line; columns offered during load are dropped.
        stream3(4, 8'h30);
        for (int c = 0; c < 3; c++) begin
            step3(1'b1, {rand_coeff(), rand_coeff(), rand_coeff()}, 1'b1, (c < 2), 24'($urandom()));
            chk($sformatf("midload_knl_done_col%0d", c), bus_a.o_knl_done, (c == 2));
            if (c < 2) begin
                step3(1'b0, 24'h0, 1'b1, 1'b0, 24'($urandom()));
                chk($sformatf("midload_no_done_%0d", c), bus_a.o_knl_done, 0);
            end
        end
        for (int i = 0; i < 4; i++) step3(1'b0, 24'h0, 1'b1, 1'b0, 24'($urandom()));
        chk("midload_done_cleared", bus_a.o_knl_done, 0);
        repeat (4) idle3();

        // Asynchronous reset with results in flight.
        load_knl3(8'h00, 8'h40);
        stream3(6, 8'h40);
        chk("pre_reset_valid", bus_a.o_valid, 1);
        chk("pre_reset_pixel", bus_a.o_pixel, 8'h20);
        #2;
        load3 = 0; valid3 = 0; sol3 = 0;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", bus_a.o_valid, 0);
        chk("async_rst_pixel", bus_a.o_pixel, 0);
        chk("async_rst_sat", bus_a.o_sat, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) idle3();
        chk("post_rst_valid", bus_a.o_valid, 0);
        for (int i = 0; i < 4; i++) step3(1'b0, 24'h0, 1'b1, (i == 0), 24'($urandom()) | 24'h010101);
        repeat (3) idle3();
        chk("zero_kernel_valid", bus_a.o_valid, 1);
        chk("zero_kernel_pixel", bus_a.o_pixel, 0);

        // Randomized traffic on the K=3 pair.
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 99);
            kc = {rand_coeff(), rand_coeff(), rand_coeff()};
            step3((r < 8), kc, (r < 80), ($urandom_range(0, 11) == 0), 24'($urandom()));
        end
        repeat (5) idle3();

        // K=5, wider output: box kernel of 0x05, pixels 0x40.
        for (int c = 0; c < 5; c++) begin
            step5(1'b1, {5{8'h05}}, 1'b0, 1'b0, 40'h0);
            chk($sformatf("knl_done_c_col%0d", c), bus_c.o_knl_done, (c == 4));
        end
        for (int i = 0; i < 7; i++) step5(1'b0, 40'h0, 1'b1, (i == 0), {5{8'h40}});
        repeat (3) step5(1'b0, 40'h0, 1'b0, 1'b0, 40'h0);
        chk("k5_valid", bus_c.o_valid, 1);
        chk("k5_pixel", bus_c.o_pixel, 10'd125);
        chk("k5_sat", bus_c.o_sat, 0);

        for (int i = 0; i < 200; i++) begin
            int r;
            r = $urandom_range(0, 99);
            kc5 = {rand_coeff(), rand_coeff(), rand_coeff(), rand_coeff(), rand_coeff()};
            step5((r < 6), kc5, (r < 85), ($urandom_range(0, 13) == 0), 40'($urandom()) ^ {8'($urandom()), 32'h0});
        end
        repeat (6) step5(1'b0, 40'h0, 1'b0, 1'b0, 40'h0);

        for (int d = 0; d < 3; d++) chk($sformatf("drained_%0d", d), exp_q[d].size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
